// File: rtl/pc_ctrl.sv
// pc_ctrl
//   Program-counter control stage for the 8-bit processor datapath. Each
//   rising edge selects the next instruction address from one of: reset,
//   stall (hold), return (pop), call (push PC+1), branch, or sequential
//   increment, in that priority. Only the highest-priority request acts;
//   the rest are dropped for that cycle. A small LIFO return stack backs
//   call/return; a call on a full stack or a return on an empty stack is
//   rejected, falls through to a plain increment, and raises a one-cycle
//   error pulse.
//
// Ports
//   clk             in   rising-edge clock
//   reset           in   synchronous, active-high reset
//   stall           in   hold pc, stack and depth this cycle
//   branch_en       in   load branch_target
//   branch_target   in   [WIDTH] branch destination
//   call_en         in   push pc+1, load call_target
//   call_target     in   [WIDTH] call destination
//   ret_en          in   pop stack top into pc
//   pc              out  [WIDTH] current instruction address (registered)
//   stack_depth     out  [clog2(DEPTH)+1] valid stack entries (registered)
//   stack_overflow  out  one-cycle pulse after a rejected call (registered)
//   stack_underflow out  one-cycle pulse after a rejected return (registered)
//
// Operation select (decided once per edge)
//   op        | meaning
//   OP_RESET  | pc <= RESET_PC, stack emptied, pulses cleared
//   OP_STALL  | everything holds, pulses cleared
//   OP_RET    | pop top into pc (or increment + underflow when empty)
//   OP_CALL   | push pc+1, pc <= call_target (or increment + overflow when full)
//   OP_BRANCH | pc <= branch_target
//   OP_INC    | pc <= pc + 1, wraps silently

module pc_ctrl #(
    parameter int              WIDTH    = 8,
    parameter int              DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = 8'h00
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic                       branch_en,
    input  logic [WIDTH-1:0]           branch_target,
    input  logic                       call_en,
    input  logic [WIDTH-1:0]           call_target,
    input  logic                       ret_en,
    output logic [WIDTH-1:0]           pc,
    output logic [$clog2(DEPTH):0]     stack_depth,
    output logic                       stack_overflow,
    output logic                       stack_underflow
);

    localparam int DW = $clog2(DEPTH) + 1;
    // Index width into the stack array; kept at least 1 bit so a
    // single-entry stack still elaborates.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        OP_RESET,
        OP_STALL,
        OP_RET,
        OP_CALL,
        OP_BRANCH,
        OP_INC
    } op_t;

    op_t              op;
    logic [WIDTH-1:0] stk [DEPTH];
    logic [WIDTH-1:0] pc_inc;
    logic             stk_full;
    logic             stk_empty;
    logic [AW-1:0]    push_idx;
    logic [AW-1:0]    pop_idx;
    logic             do_push;

    assign pc_inc    = pc + WIDTH'(1);
    assign stk_full  = (stack_depth == DW'(DEPTH));
    assign stk_empty = (stack_depth == '0);

    // Depth counts valid entries, so the next free slot is depth and the
    // top entry is depth-1. Neither index is used when it would be out of
    // range (push only when not full, pop only when not empty).
    assign push_idx  = stack_depth[AW-1:0];
    assign pop_idx   = AW'(stack_depth - DW'(1));

    always_comb begin
        op = OP_INC;
        if (reset) begin
            op = OP_RESET;
        end else if (stall) begin
            op = OP_STALL;
        end else if (ret_en) begin
            op = OP_RET;
        end else if (call_en) begin
            op = OP_CALL;
        end else if (branch_en) begin
            op = OP_BRANCH;
        end
    end

    assign do_push = (op == OP_CALL) && !stk_full;

    // Stack storage carries no reset: entries at or above depth are never
    // read, so their contents after reset do not matter.
    always_ff @(posedge clk) begin
        if (do_push) begin
            stk[push_idx] <= pc_inc;
        end
    end

    always_ff @(posedge clk) begin
        // Error pulses default low so they last exactly one cycle.
        stack_overflow  <= 1'b0;
        stack_underflow <= 1'b0;
        case (op)
            OP_RESET: begin
                pc          <= RESET_PC;
                stack_depth <= '0;
            end
            OP_STALL: begin
                pc          <= pc;
                stack_depth <= stack_depth;
            end
            OP_RET: begin
                if (stk_empty) begin
                    pc              <= pc_inc;
                    stack_underflow <= 1'b1;
                end else begin
                    pc          <= stk[pop_idx];
                    stack_depth <= stack_depth - DW'(1);
                end
            end
            OP_CALL: begin
                if (stk_full) begin
                    // Rejected call behaves like an increment.
                    pc             <= pc_inc;
                    stack_overflow <= 1'b1;
                end else begin
                    pc          <= call_target;
                    stack_depth <= stack_depth + DW'(1);
                end
            end
            OP_BRANCH: begin
                pc <= branch_target;
            end
            default: begin
                pc <= pc_inc;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_ctrl.sv
// Testbench for pc_ctrl: directed vectors, a queue-based reference model
// updated on every rising edge, one compare process on the falling edge,
// and literal expectations along the directed sequence.

module tb_pc_ctrl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk;
    logic             reset;
    logic             stall;
    logic             branch_en;
    logic [WIDTH-1:0] branch_target;
    logic             call_en;
    logic [WIDTH-1:0] call_target;
    logic             ret_en;
    logic [WIDTH-1:0] pc;
    logic [2:0]       stack_depth;
    logic             stack_overflow;
    logic             stack_underflow;

    int checks   = 0;
    int failures = 0;

    pc_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_PC(8'h00)) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .branch_en       (branch_en),
        .branch_target   (branch_target),
        .call_en         (call_en),
        .call_target     (call_target),
        .ret_en          (ret_en),
        .pc              (pc),
        .stack_depth     (stack_depth),
        .stack_overflow  (stack_overflow),
        .stack_underflow (stack_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integers and a queue used as a LIFO.
    int m_pc;
    int m_stk[$];
    int m_ovf;
    int m_unf;
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_pc = 0;
            m_stk.delete();
            m_ovf = 0;
            m_unf = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_ovf = 0;
            m_unf = 0;
            if (stall) begin
                // hold
            end else if (ret_en) begin
                if (m_stk.size() > 0) begin
                    m_pc = m_stk.pop_back();
                end else begin
                    m_pc = (m_pc + 1) % 256;
                    m_unf = 1;
                end
            end else if (call_en) begin
                if (m_stk.size() < DEPTH) begin
                    m_stk.push_back((m_pc + 1) % 256);
                    m_pc = int'(call_target);
                end else begin
                    m_pc = (m_pc + 1) % 256;
                    m_ovf = 1;
                end
            end else if (branch_en) begin
                m_pc = int'(branch_target);
            end else begin
                m_pc = (m_pc + 1) % 256;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_pc",    int'(pc),              m_pc);
            check("model_depth", int'(stack_depth),     m_stk.size());
            check("model_ovf",   int'(stack_overflow),  m_ovf);
            check("model_unf",   int'(stack_underflow), m_unf);
        end
    end

    // Drive one cycle of inputs, then return at the following falling edge
    // (after the rising edge that consumed them).
    task automatic cyc(input bit rs, input bit st, input bit br, input int bt,
                       input bit ca, input int ct, input bit rt);
        reset         = rs;
        stall         = st;
        branch_en     = br;
        branch_target = WIDTH'(bt);
        call_en       = ca;
        call_target   = WIDTH'(ct);
        ret_en        = rt;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic expect_out(input string name, input int epc, input int edep,
                              input int eovf, input int eunf);
        check({name, "_pc"},    int'(pc),              epc);
        check({name, "_depth"}, int'(stack_depth),     edep);
        check({name, "_ovf"},   int'(stack_overflow),  eovf);
        check({name, "_unf"},   int'(stack_underflow), eunf);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; branch_en = 1'b0; branch_target = '0;
        call_en = 1'b0; call_target = '0; ret_en = 1'b0;

        // 1. Reset and increment
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        expect_out("rst", 8'h00, 0, 0, 0);
        idle(); expect_out("inc1", 8'h01, 0, 0, 0);
        idle(); expect_out("inc2", 8'h02, 0, 0, 0);
        idle(); expect_out("inc3", 8'h03, 0, 0, 0);

        // 2. Wrap, branch, stall
        cyc(0, 0, 1, 8'hFE, 0, 0, 0); expect_out("br_fe", 8'hFE, 0, 0, 0);
        idle(); expect_out("wrap_ff", 8'hFF, 0, 0, 0);
        idle(); expect_out("wrap_00", 8'h00, 0, 0, 0);
        cyc(0, 1, 1, 8'h40, 0, 0, 0); expect_out("stall_br", 8'h00, 0, 0, 0);
        cyc(0, 0, 1, 8'h40, 0, 0, 0); expect_out("br_40", 8'h40, 0, 0, 0);

        // 3. Nested call/return
        cyc(0, 0, 1, 8'h10, 0, 0, 0); expect_out("br_10", 8'h10, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 8'h20, 0); expect_out("call20", 8'h20, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 8'h30, 0); expect_out("call30", 8'h30, 2, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);     expect_out("ret21", 8'h21, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);     expect_out("ret11", 8'h11, 0, 0, 0);

        // 4. Overflow (pc = 11, so the first push is 12)
        cyc(0, 0, 0, 0, 1, 8'h50, 0); expect_out("call50", 8'h50, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 8'h60, 0); expect_out("call60", 8'h60, 2, 0, 0);
        cyc(0, 0, 0, 0, 1, 8'h70, 0); expect_out("call70", 8'h70, 3, 0, 0);
        cyc(0, 0, 0, 0, 1, 8'h80, 0); expect_out("call80", 8'h80, 4, 0, 0);
        cyc(0, 0, 0, 0, 1, 8'h90, 0); expect_out("ovf", 8'h81, 4, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);     expect_out("ret71", 8'h71, 3, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);     expect_out("ret61", 8'h61, 2, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);     expect_out("ret51", 8'h51, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);     expect_out("ret12", 8'h12, 0, 0, 0);

        // 5. Underflow and priority
        cyc(0, 0, 1, 8'h33, 0, 0, 0); expect_out("br_33", 8'h33, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);     expect_out("unf", 8'h34, 0, 0, 1);
        idle();                        expect_out("unf_clr", 8'h35, 0, 0, 0);
        cyc(0, 0, 1, 8'h43, 0, 0, 0); expect_out("br_43", 8'h43, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 8'hA0, 0); expect_out("call_a0", 8'hA0, 1, 0, 0);
        cyc(0, 0, 1, 8'hC0, 1, 8'hB0, 1); expect_out("prio", 8'h44, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);     expect_out("prio_nopush", 8'h45, 0, 0, 1);

        // 6. Reset mid-operation (call held for 3 cycles = 3 pushes)
        cyc(0, 0, 0, 0, 1, 8'h20, 0);
        cyc(0, 0, 0, 0, 1, 8'h20, 0);
        cyc(0, 0, 0, 0, 1, 8'h20, 0); expect_out("depth3", 8'h20, 3, 0, 0);
        cyc(0, 1, 0, 0, 1, 8'h90, 0); expect_out("stall_call", 8'h20, 3, 0, 0);
        cyc(1, 0, 0, 0, 1, 8'h90, 0); expect_out("rst_mid", 8'h00, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);     expect_out("rst_unf", 8'h01, 0, 0, 1);
        idle();                        expect_out("tail", 8'h02, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
